// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_INSTR = 32'h0010_0073;

  typedef enum logic {RUN, HALTED} fetch_state_t;

  // Contents of the IF/ID output slot.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } id_slot_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: InstructionMemory port, redirect input, IF/ID slot, status.
// The master modport is the fetch unit; slave is the surrounding pipeline/memory.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               fetch_en;
  logic [INSTR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [INSTR_W-1:0] redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [INSTR_W-1:0] id_pc;
  logic               halted;
  logic [INSTR_W-1:0] fetch_count;

  modport master (
    input  fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    output imem_addr, id_valid, id_instr, id_pc, halted, fetch_count
  );

  modport slave (
    output fetch_en, imem_instr, redirect_valid, redirect_pc, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc, halted, fetch_count
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter with next-PC select: redirect beats increment beats hold.
// Latency: new PC visible the cycle after load/redirect; holds whenever neither is asserted.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] pc
);

  logic [INSTR_W-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    if (redirect_valid) begin
      pc_nxt = redirect_pc & ~32'h3;
    end else if (load) begin
      pc_nxt = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC & ~32'h3;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives InstructionMemory from the PC and registers instr+PC into the IF/ID slot.
// Latency one cycle; slot stalls (pc, id_instr, id_pc stable) while id_valid && !id_ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_unit_if.master bus
);

  fetch_state_t       state, state_nxt;
  logic [INSTR_W-1:0] pc;
  id_slot_t           slot;
  logic               slot_vld;
  logic [INSTR_W-1:0] cnt;
  logic               slot_free;
  logic               load;
  logic               handshake;

  assign handshake = slot_vld && bus.id_ready;
  assign slot_free = !slot_vld || bus.id_ready;
  assign load      = (state == RUN) && bus.fetch_en && slot_free && !bus.redirect_valid;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .pc             (pc)
  );

  // Halting is decided on the instruction being loaded; only a redirect resumes.
  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = RUN;
    end else if (load && (bus.imem_instr == HALT_INSTR)) begin
      state_nxt = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect flushes the slot even when the decoder takes it in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld <= 1'b0;
      slot     <= '0;
    end else if (bus.redirect_valid) begin
      slot_vld <= 1'b0;
    end else if (load) begin
      slot_vld   <= 1'b1;
      slot.pc    <= pc;
      slot.instr <= bus.imem_instr;
    end else if (handshake) begin
      slot_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (handshake) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign bus.imem_addr   = {2'b00, pc[31:2]};
  assign bus.id_valid    = slot_vld;
  assign bus.id_instr    = slot.instr;
  assign bus.id_pc       = slot.pc;
  assign bus.halted      = (state == HALTED);
  assign bus.fetch_count = cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed program walk plus random traffic, checked against a transaction-level fetch model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] HALT = 32'h0010_0073;
  localparam logic [31:0] PROG [0:3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0010_0073};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // model state
  logic [31:0] m_pc, m_out_pc, m_out_instr, m_cnt;
  logic        m_vld, m_halt;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] widx);
    if (widx < 32'd4) return PROG[widx[1:0]];
    return (widx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_instr = imem_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_vld = 1'b0; m_out_pc = 32'h0; m_out_instr = 32'h0;
    m_halt = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(m_vld));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halt));
    chk({tag, ".fetch_count"}, bus.fetch_count, m_cnt);
    chk({tag, ".imem_addr"}, bus.imem_addr, m_pc >> 2);
    if (m_vld) begin
      chk({tag, ".id_pc"}, bus.id_pc, m_out_pc);
      chk({tag, ".id_instr"}, bus.id_instr, m_out_instr);
    end
  endtask

  // Called at a falling edge: apply inputs, advance the model across the next
  // rising edge, then compare at the following falling edge.
  task automatic step(input string tag, input logic fe, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    logic taken, fetch;
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.id_ready       = rdy;
    taken = m_vld && rdy;
    fetch = !m_halt && fe && (!m_vld || rdy) && !rv;
    if (taken) m_cnt = m_cnt + 1;
    if (rv) begin
      m_pc = {rpc[31:2], 2'b00};
      m_vld = 1'b0;
      m_halt = 1'b0;
    end else if (fetch) begin
      m_out_pc = m_pc;
      m_out_instr = imem_word(m_pc >> 2);
      m_vld = 1'b1;
      if (m_out_instr == HALT) m_halt = 1'b1;
      m_pc = m_pc + 32'd4;
    end else if (taken) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    bus.fetch_en = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // stream the program with id_ready high; halts after word3
    for (int i = 0; i < 4; i++) step("stream", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stream.last_pc", bus.id_pc, 32'd12);
    chk("stream.halted", 32'(bus.halted), 32'd1);
    step("drain", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("drain.count", bus.fetch_count, 32'd4);

    // halted: fetch_en high does not fetch
    for (int i = 0; i < 5; i++) step("halt_hold", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_hold.valid", 32'(bus.id_valid), 32'd0);
    step("halt_redir", 1'b1, 1'b1, 32'h0, 1'b1);
    chk("halt_redir.halted", 32'(bus.halted), 32'd0);
    step("halt_resume", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_resume.pc", bus.id_pc, 32'd0);

    // backpressure while id_pc=4
    step("bp_load", 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step("bp_stall", 1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp.instr", bus.id_instr, 32'h00A0_0113);
    chk("bp.imem_addr", bus.imem_addr, 32'd2);
    step("bp_resume", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("bp_resume.pc", bus.id_pc, 32'd8);

    // redirect flush while id_pc=4 valid (start from 0)
    step("fl_redir0", 1'b1, 1'b1, 32'h0, 1'b1);
    step("fl_a", 1'b1, 1'b0, 32'h0, 1'b0);
    step("fl_b", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("fl.pre_pc", bus.id_pc, 32'd4);
    step("fl_redir", 1'b1, 1'b1, 32'h6, 1'b1);
    chk("fl.valid", 32'(bus.id_valid), 32'd0);
    chk("fl.addr", bus.imem_addr, 32'd1);
    step("fl_again", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("fl_again.pc", bus.id_pc, 32'd4);

    // wrap at top of address space
    step("wrap_redir", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step("wrap_fetch", 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap.id_pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap.addr", bus.imem_addr, 32'd0);

    // asynchronous reset mid-run with id_valid=1, pc=8
    step("ar_redir", 1'b1, 1'b1, 32'h0, 1'b1);
    step("ar_a", 1'b1, 1'b0, 32'h0, 1'b1);
    step("ar_b", 1'b1, 1'b0, 32'h0, 1'b1);
    chk("ar.pre_addr", bus.imem_addr, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(bus.id_valid), 32'd0);
    chk("ar.count", bus.fetch_count, 32'd0);
    chk("ar.addr", bus.imem_addr, 32'd0);
    model_reset();
    @(negedge clk);
    compare_all("ar_hold");
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 40));
      step("rand", ($urandom_range(0, 4) != 0), ($urandom_range(0, 11) == 0), rpc,
           ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
